uart_trace_printer: RTL and testbench
=====================================

Name: uart_trace_printer

Overview:
- Multi-channel debug trace printer that replaces the single-value, print-every-cycle UART debug path in the top level.
- Watches NUM_CH values of WIDTH bits each and buffers capture events in a FIFO.
- Serialises each event as an ASCII hex line on an 8N1 UART transmit pin.
- Optional change-only filtering, so a stalled PC or address does not flood the link.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period is CLK_HZ/BAUD cycles (integer, truncated, at least 2).
- NUM_CH, 4, number of watched channels (1..16).
- WIDTH, 16, bits per channel. Must be a multiple of 4.
- DEPTH, 8, event FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- trace_in  in  NUM_CH*WIDTH  channel values; channel k occupies bits [k*WIDTH +: WIDTH]
- trace_valid  in  NUM_CH  per-channel sample strobe, one cycle per sample
- change_only  in  1  0 = print every strobe; 1 = print only when the value differs from that channel's last captured value
- txp  out  1  UART TX, idle high
- busy  out  1  high while any pending, FIFO or serializer activity exists
- drop_count  out  8  saturating count of overwritten pending samples
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, immediate):
  - txp=1, busy=0, drop_count=0, fifo_level=0.
  - All pending flags, seen flags, FIFO pointers and serializer state cleared.
  - Any frame in progress is aborted. Nothing resumes after release.
- Capture:
  - On a clk edge with trace_valid[k]=1, channel k's sample is accepted unless change_only=1, seen[k]=1 and the value equals last[k].
  - An accepted sample writes pending[k]=1, pend_val[k]=value, last[k]=value, seen[k]=1.
  - Filtered samples are ignored entirely.
- Drop:
  - An accepted sample arriving while pending[k]=1 and channel k is not being pushed that same edge overwrites pend_val[k] and increments drop_count (saturates at 255).
  - If channel k is pushed on the same edge, the old value is pushed, the new value becomes pending and no drop is counted.
- Arbiter:
  - Each edge, if the FIFO is not full, the lowest-index channel with pending set pushes {channel, pend_val} and clears its pending flag.
  - At most one push per cycle. A pending sample waits while the FIFO is full and is never lost merely because of the wait.
- FIFO:
  - DEPTH entries, registered pointers. Push and pop on the same edge are both honoured.
  - Full: no push. Empty: no pop. Pointers wrap modulo DEPTH.
- Serializer FSM: IDLE -> LOAD -> START -> DATA -> STOP -> next byte or IDLE.
  - IDLE: pops when FIFO non-empty. Pop-to-start-bit latency is at most 2 cycles.
  - Each byte: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLK_HZ/BAUD cycles.
  - Bytes are back-to-back with no idle gap within a line.
- Line format, 4+WIDTH/4 bytes:
  - one uppercase hex digit for the channel index;
  - ':' (0x3A);
  - WIDTH/4 uppercase hex digits of the value, MSB nibble first;
  - 0x0D, then 0x0A.
  - Digits 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- busy = any pending | fifo_level!=0 | FSM!=IDLE.

Test Plan:
- Bench parameters: CLK_HZ=8, BAUD=1 (8 cycles/bit, 80 cycles/byte), WIDTH=16, NUM_CH=4, DEPTH=2 unless noted.
- Formatting: ch0=0x1A2F strobed once -> txp emits 30 3A 31 41 32 46 0D 0A (8 bytes, 640 cycles), start bits low, LSB first; busy falls after the last stop bit.
- Filtering: ch1=0x00FF strobed 5 times with change_only=1 -> exactly one line "1:00FF". Repeat with change_only=0 -> five identical lines, drop_count=0 (strobes spaced at least 700 cycles apart).
- Simultaneous strobes: ch0=0x0001 and ch2=0xBEEF in the same cycle -> line "0:0001" first, then "2:BEEF"; fifo_level peaks at 1; drop_count=0.
- Overflow/drop: ch1 strobes 0x0001..0x0008 on 8 consecutive cycles -> printed lines 0001, 0002, 0003, 0008 in order; drop_count=4; no line lost after the FIFO drains.
- Saturation: 300 forced overwrites -> drop_count holds at 255.
- Reset mid-frame: assert reset during byte 3 of a line -> txp=1, busy=0, fifo_level=0, drop_count=0 in the same cycle. After release, txp stays high until a new strobe, whose line prints complete and correct.

Source files
------------

// File: rtl/uart_trace_printer.sv
// Multi-channel trace printer: captures strobed channel values into a FIFO and
// prints each event as an ASCII hex line "C:VVVV\r\n" on an 8N1 UART pin.
module uart_trace_printer #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200,
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*WIDTH-1:0]     trace_in,
  input  logic [NUM_CH-1:0]           trace_valid,
  input  logic                        change_only,
  output logic                        txp,
  output logic                        busy,
  output logic [7:0]                  drop_count,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level
);

  localparam int BIT_CYC = (CLK_HZ / BAUD < 2) ? 2 : CLK_HZ / BAUD;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam int NIB     = WIDTH / 4;
  localparam int NBYTES  = NIB + 4;
  localparam int BYTE_W  = $clog2(NBYTES);
  localparam int ENTRY_W = 4 + WIDTH;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  logic [NUM_CH-1:0]             pending_vec;
  logic [NUM_CH-1:0][WIDTH-1:0]  pend_vals;
  logic [NUM_CH-1:0]             accept;
  logic [NUM_CH-1:0]             dropped;
  logic [NUM_CH-1:0]             grant;
  logic                          push;
  logic                          pop;
  logic [3:0]                    push_ch;
  logic [WIDTH-1:0]              push_val;
  logic                          fifo_full;
  logic                          fifo_empty;

  logic [7:0]                    drop_count_reg;
  logic [7:0]                    drop_count_next;
  logic [8:0]                    drop_total;

  logic [ENTRY_W-1:0]            mem [DEPTH];
  logic [ENTRY_W-1:0]            rd_data_reg;
  logic [AW-1:0]                 wr_ptr_reg;
  logic [AW-1:0]                 rd_ptr_reg;
  logic [LW-1:0]                 count_reg;

  state_t                        state_reg;
  state_t                        state_next;
  logic [ENTRY_W-1:0]            line_reg;
  logic [BYTE_W-1:0]             byte_idx_reg;
  logic [2:0]                    bit_idx_reg;
  logic [CNT_W-1:0]              baud_cnt_reg;
  logic                          bit_done;
  logic                          last_byte;
  logic [7:0]                    tx_byte;
  logic [WIDTH-1:0]              value_shift;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Per-channel capture state: the new sample always wins the pending slot,
  // while a same-edge grant still pushes the previous value.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] sample;
    logic             pending_reg;
    logic             seen_reg;
    logic [WIDTH-1:0] pend_val_reg;
    logic [WIDTH-1:0] last_reg;

    assign sample          = trace_in[gi*WIDTH +: WIDTH];
    assign accept[gi]      = trace_valid[gi] &
                             ~(change_only & seen_reg & (sample == last_reg));
    assign dropped[gi]     = accept[gi] & pending_reg & ~grant[gi];
    assign pending_vec[gi] = pending_reg;
    assign pend_vals[gi]   = pend_val_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pending_reg  <= 1'b0;
        seen_reg     <= 1'b0;
        pend_val_reg <= '0;
        last_reg     <= '0;
      end else if (accept[gi]) begin
        pending_reg  <= 1'b1;
        seen_reg     <= 1'b1;
        pend_val_reg <= sample;
        last_reg     <= sample;
      end else if (grant[gi]) begin
        pending_reg  <= 1'b0;
      end
    end
  end

  always_comb begin
    grant    = '0;
    push_ch  = '0;
    push_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_vec[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        push_ch  = 4'(i);
        push_val = pend_vals[i];
      end
    end
    if (fifo_full) grant = '0;
    push = |grant;
  end

  always_comb begin
    drop_total = {1'b0, drop_count_reg};
    for (int i = 0; i < NUM_CH; i++) drop_total = drop_total + 9'(dropped[i]);
    drop_count_next = drop_total[8] ? 8'hFF : drop_total[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_count_reg <= '0;
    else       drop_count_reg <= drop_count_next;
  end

  assign fifo_full  = (count_reg == LW'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = (state_reg == S_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {push_ch, push_val};
    if (pop)  rd_data_reg     <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign bit_done  = (baud_cnt_reg == CNT_W'(BIT_CYC - 1));
  assign last_byte = (byte_idx_reg == BYTE_W'(NBYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!fifo_empty) state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
      S_DATA:  if (bit_done && bit_idx_reg == 3'd7) state_next = S_STOP;
      S_STOP:  if (bit_done) state_next = last_byte ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_reg     <= '0;
      byte_idx_reg <= '0;
      bit_idx_reg  <= '0;
      baud_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          line_reg     <= rd_data_reg;
          byte_idx_reg <= '0;
          bit_idx_reg  <= '0;
          baud_cnt_reg <= '0;
        end
        S_START, S_DATA, S_STOP: begin
          baud_cnt_reg <= bit_done ? '0 : baud_cnt_reg + CNT_W'(1);
          if (state_reg == S_DATA && bit_done) bit_idx_reg <= bit_idx_reg + 3'd1;
          if (state_reg == S_STOP && bit_done) byte_idx_reg <= byte_idx_reg + BYTE_W'(1);
        end
        default: baud_cnt_reg <= '0;
      endcase
    end
  end

  // Byte 0 is the channel digit, 1 the colon, then value nibbles MSB first, CR, LF.
  always_comb begin
    value_shift = '0;
    if (byte_idx_reg == '0) begin
      tx_byte = hex_ascii(line_reg[ENTRY_W-1 -: 4]);
    end else if (byte_idx_reg == BYTE_W'(1)) begin
      tx_byte = 8'h3A;
    end else if (byte_idx_reg == BYTE_W'(NBYTES - 2)) begin
      tx_byte = 8'h0D;
    end else if (byte_idx_reg == BYTE_W'(NBYTES - 1)) begin
      tx_byte = 8'h0A;
    end else begin
      value_shift = line_reg[WIDTH-1:0] >> (4 * (NIB + 1 - int'(byte_idx_reg)));
      tx_byte     = hex_ascii(value_shift[3:0]);
    end
  end

  always_comb begin
    txp  = 1'b1;
    busy = (|pending_vec) || (count_reg != '0) || (state_reg != S_IDLE);
    case (state_reg)
      S_START: txp = 1'b0;
      S_DATA:  txp = tx_byte[bit_idx_reg];
      default: txp = 1'b1;
    endcase
  end

  assign drop_count = drop_count_reg;
  assign fifo_level = count_reg;

endmodule

// File: tb/tb_uart_trace_printer.sv
// Directed plus randomized bench for uart_trace_printer: a UART receiver decodes
// txp and every printed line is compared against a line-level reference model.
module tb_uart_trace_printer;
  localparam int BIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] trace_in;
  logic [3:0]  trace_valid;
  logic        change_only;
  logic        txp;
  logic        busy;
  logic [7:0]  drop_count;
  logic [1:0]  fifo_level;

  uart_trace_printer #(
    .CLK_HZ(8), .BAUD(1), .NUM_CH(4), .WIDTH(16), .DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .trace_in(trace_in), .trace_valid(trace_valid),
    .change_only(change_only), .txp(txp), .busy(busy),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         bad_stop = 0;
  int         peak_level = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         seen_m[4];
  logic [15:0] last_m[4];

  // Receiver: samples mid-bit on negedges; bytes interrupted by reset are discarded.
  initial begin
    logic [7:0] data;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txp !== 1'b0) continue;
      aborted = 1'b0;
      repeat (BIT / 2) begin @(negedge clk); if (reset) aborted = 1'b1; end
      for (int b = 0; b < 8; b++) begin
        repeat (BIT) begin @(negedge clk); if (reset) aborted = 1'b1; end
        data[b] = txp;
      end
      repeat (BIT) begin @(negedge clk); if (reset) aborted = 1'b1; end
      if (!aborted) begin
        rx_q.push_back(data);
        if (txp !== 1'b1) bad_stop++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 10) ? (8'd48 + 8'(n)) : (8'd65 + 8'(n) - 8'd10);
  endfunction

  task automatic expect_line(input int ch, input logic [15:0] val);
    exp_q.push_back(asc(4'(ch)));
    exp_q.push_back(8'h3A);
    for (int k = 3; k >= 0; k--) exp_q.push_back(asc(val[k*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin seen_m[c] = 1'b0; last_m[c] = '0; end
  endtask

  // One strobe group with nothing else pending: accepted channels print in index order.
  task automatic model_group(input logic [3:0] mask, input logic [63:0] vals);
    logic [15:0] v;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        v = vals[c*16 +: 16];
        if (!(change_only && seen_m[c] && last_m[c] == v)) begin
          seen_m[c] = 1'b1;
          last_m[c] = v;
          expect_line(c, v);
        end
      end
    end
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [63:0] vals);
    trace_in    = vals;
    trace_valid = mask;
    tick();
    trace_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (8) tick();
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_bytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  fmt_exp [8];
    logic [63:0] vals;
    logic [3:0]  mask;
    int          n;
    bit          low_seen;

    reset = 1'b1; trace_in = '0; trace_valid = '0; change_only = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_txp", {31'd0, txp}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_level", {30'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Formatting: fixed expected bytes and line duration.
    fmt_exp = '{8'h30, 8'h3A, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    strobe(4'b0001, 64'h1A2F);
    model_group(4'b0001, 64'h1A2F);
    exp_q.delete();
    n = 0;
    while (busy === 1'b1 && n < 1000) begin tick(); n++; end
    check("fmt_busy_len_in_range", {31'd0, (n >= 642 && n <= 645)}, 32'd1);
    repeat (8) tick();
    check("fmt_txp_idle", {31'd0, txp}, 32'd1);
    check("fmt_bytes", rx_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check($sformatf("fmt_b%0d", i), {24'd0, rx_q[i]}, {24'd0, fmt_exp[i]});
    rx_q.delete();

    // Filtering with and without change_only.
    change_only = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(4'b0010, 64'h00FF_0000);
      model_group(4'b0010, 64'h00FF_0000);
      repeat (700) tick();
    end
    wait_idle(2000);
    compare_rx("filt_co1");
    change_only = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(4'b0010, 64'h00FF_0000);
      model_group(4'b0010, 64'h00FF_0000);
      repeat (700) tick();
    end
    wait_idle(2000);
    compare_rx("filt_co0");
    check("filt_drop", {24'd0, drop_count}, 32'd0);

    // Simultaneous strobes.
    peak_level = 0;
    strobe(4'b0101, 64'h0000_BEEF_0000_0001);
    model_group(4'b0101, 64'h0000_BEEF_0000_0001);
    wait_idle(3000);
    compare_rx("simul");
    check("simul_peak", peak_level, 32'd1);
    check("simul_drop", {24'd0, drop_count}, 32'd0);

    // Overflow: eight back-to-back samples on channel 1.
    for (int v = 1; v <= 8; v++) begin
      trace_in = {32'd0, 16'(v), 16'd0};
      trace_valid = 4'b0010;
      tick();
    end
    trace_valid = '0;
    expect_line(1, 16'h0001); expect_line(1, 16'h0002);
    expect_line(1, 16'h0003); expect_line(1, 16'h0008);
    seen_m[1] = 1'b1; last_m[1] = 16'h0008;
    check("ovf_drop", {24'd0, drop_count}, 32'd4);
    wait_idle(5000);
    compare_rx("ovf");

    // Saturation of drop_count.
    reset = 1'b1; tick(); reset = 1'b0; model_reset(); tick();
    for (int v = 1; v <= 310; v++) begin
      trace_in = {16'(v), 48'd0};
      trace_valid = 4'b1000;
      tick();
    end
    trace_valid = '0;
    check("sat_drop", {24'd0, drop_count}, 32'd255);
    expect_line(3, 16'd1); expect_line(3, 16'd2); expect_line(3, 16'd3); expect_line(3, 16'd310);
    wait_idle(5000);
    compare_rx("sat");
    check("sat_drop_hold", {24'd0, drop_count}, 32'd255);

    // Reset in the middle of byte 3.
    reset = 1'b1; tick(); reset = 1'b0; model_reset(); tick();
    change_only = 1'b1;
    strobe(4'b1111, 64'h4444_3333_2222_1111);
    repeat (5) tick();
    strobe(4'b1000, 64'h4445_0000_0000_0000);
    n = 0;
    while (rx_q.size() < 2 && n < 400) begin tick(); n++; end
    check("mid_two_bytes", rx_q.size(), 32'd2);
    repeat (20) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_level", {30'd0, fifo_level}, 32'd2);
    check("mid_drop", {24'd0, drop_count}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_txp", {31'd0, txp}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_level", {30'd0, fifo_level}, 32'd0);
    check("async_drop", {24'd0, drop_count}, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    low_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin tick(); if (txp !== 1'b1) low_seen = 1'b1; end
    check("post_rst_txp_high", {31'd0, low_seen}, 32'd0);
    rx_q.delete();
    exp_q.delete();
    strobe(4'b0100, 64'h0000_3333_0000_0000);
    model_group(4'b0100, 64'h0000_3333_0000_0000);
    wait_idle(2000);
    compare_rx("post_rst");

    // Randomized strobe groups, each drained before the next.
    for (int g = 0; g < 8; g++) begin
      change_only = 1'($urandom_range(0, 1));
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++)
        vals[c*16 +: 16] = (seen_m[c] && $urandom_range(0, 1) == 1) ? last_m[c] : 16'($urandom);
      repeat ($urandom_range(0, 20)) tick();
      strobe(mask, vals);
      model_group(mask, vals);
      wait_idle(4000);
      compare_rx($sformatf("rand%0d", g));
    end
    check("rand_drop", {24'd0, drop_count}, 32'd0);
    check("stop_bits", bad_stop, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
